// File: rtl/clkdet_pkg.sv
// Shared definitions for the divided-clock detector: FSM encoding, known divider periods, helpers.
package clkdet_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } clkdet_state_t;

    localparam int unsigned DIV2_PERIOD = 2;
    localparam int unsigned DIV4_PERIOD = 4;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/clkdet_sync_edge.sv
// Synchronises divclk into the clkin domain and emits registered one-cycle rise/fall strobes.
module clkdet_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clkin,
    input  logic rst,
    input  logic divclk,
    output logic rise_stb,
    output logic fall_stb
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clkin) begin
        if (rst) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], divclk};
            prev_q   <= sync_q[SYNC_STAGES-1];
            rise_stb <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_stb <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

endmodule

// File: rtl/clkdiv_detect.sv
// Measures the period of an incoming divided clock, locks when stable and flags div2/div4.
// Optional duty-cycle qualification of lock is enabled by defining CLKDET_DUTY_CHECK_EN.
module clkdiv_detect
    import clkdet_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned TOL         = 0
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             divclk,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] period,
    output logic             locked,
    output logic             is_div2,
    output logic             is_div4,
    output logic             duty_ok
);

    localparam int unsigned   MATCH_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    clkdet_state_t      state_q, state_d;
    logic [CNT_W-1:0]   per_cnt, meas_c, period_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               timeout_c, match_c, duty_now_c, duty_d, locked_d;

    clkdet_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clkin    (clkin),
        .rst      (rst),
        .divclk   (divclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // A rise arriving exactly at saturation still counts as a (saturated) measurement.
    assign meas_c    = (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + CNT_W'(1);
    assign timeout_c = (per_cnt == CNT_MAX) && !rise_stb;

    always_ff @(posedge clkin) begin
        if (rst)                  per_cnt <= '0;
        else if (rise_stb)        per_cnt <= '0;
        else if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_W'(1);
    end

`ifdef CLKDET_DUTY_CHECK_EN
    logic [CNT_W-1:0] hi_run, hi_cnt, low_c;

    always_ff @(posedge clkin) begin
        if (rst) begin
            hi_run <= '0;
            hi_cnt <= '0;
        end else begin
            if (rise_stb)                hi_run <= '0;
            else if (hi_run != CNT_MAX)  hi_run <= hi_run + CNT_W'(1);
            if (fall_stb) hi_cnt <= (hi_run == CNT_MAX) ? CNT_MAX : hi_run + CNT_W'(1);
        end
    end

    assign low_c      = (meas_c >= hi_cnt) ? (meas_c - hi_cnt) : '0;
    assign duty_now_c = abs_diff(32'(hi_cnt), 32'(low_c)) <= 32'(TOL);
`else
    assign duty_now_c = 1'b1;
`endif

    assign match_c = (abs_diff(32'(meas_c), 32'(period)) <= 32'(TOL)) && duty_now_c;

    always_comb begin
        state_d  = state_q;
        period_d = period;
        match_d  = match_q;
        duty_d   = duty_ok;
        if (timeout_c) begin
            state_d  = IDLE;
            period_d = '0;
            match_d  = '0;
            duty_d   = 1'b1;
        end else if (rise_stb) begin
            case (state_q)
                IDLE: state_d = ACQ;
                ACQ: begin
                    state_d  = TRACK;
                    period_d = meas_c;
                    match_d  = '0;
                    duty_d   = duty_now_c;
                end
                TRACK: begin
                    period_d = meas_c;
                    duty_d   = duty_now_c;
                    if (match_c) begin
                        match_d = match_q + MATCH_W'(1);
                        if (32'(match_q) + 32'd1 >= 32'(LOCK_COUNT)) state_d = LOCKED;
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    period_d = meas_c;
                    duty_d   = duty_now_c;
                    if (!match_c) begin
                        state_d = TRACK;
                        match_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q <= IDLE;
            period  <= '0;
            match_q <= '0;
            locked  <= 1'b0;
            is_div2 <= 1'b0;
            is_div4 <= 1'b0;
            duty_ok <= 1'b1;
        end else begin
            state_q <= state_d;
            period  <= period_d;
            match_q <= match_d;
            locked  <= locked_d;
            is_div2 <= locked_d && (period_d == CNT_W'(DIV2_PERIOD));
            is_div4 <= locked_d && (period_d == CNT_W'(DIV4_PERIOD));
            duty_ok <= duty_d;
        end
    end

endmodule
